// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared frame geometry, pixel/window types and sizing helper for
//            the CNN front-end blocks.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DATA_W     = 8;
    localparam int IMG_HEIGHT = 28;
    localparam int IMG_WIDTH  = 28;
    localparam int OUT_H      = IMG_HEIGHT - 2;
    localparam int OUT_W      = IMG_WIDTH - 2;
    localparam int WIN_SIZE   = 9;

    typedef logic [DATA_W-1:0]     pixel_t;
    typedef pixel_t [WIN_SIZE-1:0] window_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_line_buffer
// Brief    : One image row of pixel storage, asynchronous read and synchronous
//            write at the same column, so a read returns the pre-write value.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter  int DEPTH  = cnn_pkg::IMG_WIDTH,
    parameter  int DATA_W = cnn_pkg::DATA_W,
    localparam int ADDR_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign rd_data = r_mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen
// Brief    : Streaming 3x3 stride-1 window generator over a raster pixel
//            stream, two line buffers plus a shifting 3x3 register window.
//            Optional stall counter port enabled by CONV_WINDOW_GEN_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter  int IMG_HEIGHT = cnn_pkg::IMG_HEIGHT,
    parameter  int IMG_WIDTH  = cnn_pkg::IMG_WIDTH,
    parameter  int DATA_W     = cnn_pkg::DATA_W,
    // A 3-pixel dimension has a single output position; keep one bit there.
    localparam int ROW_W      = cnt_width(IMG_HEIGHT - 2),
    localparam int COL_W      = cnt_width(IMG_WIDTH - 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [9*DATA_W-1:0]   win_data,
    output logic [ROW_W-1:0]      win_row,
    output logic [COL_W-1:0]      win_col,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  win_last
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int OUT_H   = IMG_HEIGHT - 2;
    localparam int OUT_W   = IMG_WIDTH - 2;
    localparam int R_CNT_W = cnt_width(IMG_HEIGHT);
    localparam int C_CNT_W = cnt_width(IMG_WIDTH);

    logic [R_CNT_W-1:0]                r_row_cnt;
    logic [C_CNT_W-1:0]                r_col_cnt;
    logic [WIN_SIZE-1:0][DATA_W-1:0]   r_win;
    logic [WIN_SIZE-1:0][DATA_W-1:0]   w_win_next;
    logic                              r_win_valid;
    logic                              r_win_last;
    logic [ROW_W-1:0]                  r_win_row;
    logic [COL_W-1:0]                  r_win_col;

    logic                              w_accept;
    logic                              w_fire;
    logic                              w_lb_we;
    logic                              w_col_end;
    logic                              w_row_end;
    logic                              w_emit;
    logic [DATA_W-1:0]                 w_lb0_rd;
    logic [DATA_W-1:0]                 w_lb1_rd;

    assign pix_ready = !r_win_valid || win_ready;
    assign w_accept  = pix_valid && pix_ready;
    assign w_fire    = r_win_valid && win_ready;
    assign w_lb_we   = w_accept && rst_n && !clear;

    assign w_col_end = (r_col_cnt == C_CNT_W'(OUT_W + 1));
    assign w_row_end = (r_row_cnt == R_CNT_W'(OUT_H + 1));
    assign w_emit    = (r_row_cnt >= R_CNT_W'(2)) && (r_col_cnt >= C_CNT_W'(2));

    // lb0 holds the previous row, lb1 the row before it.
    cnn_line_buffer #(
        .DEPTH   (IMG_WIDTH),
        .DATA_W  (DATA_W)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (w_lb_we),
        .addr    (r_col_cnt),
        .wr_data (pix_in),
        .rd_data (w_lb0_rd)
    );

    cnn_line_buffer #(
        .DEPTH   (IMG_WIDTH),
        .DATA_W  (DATA_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (w_lb_we),
        .addr    (r_col_cnt),
        .wr_data (w_lb0_rd),
        .rd_data (w_lb1_rd)
    );

    always_comb begin
        w_win_next = r_win;
        for (int i = 0; i < 3; i++) begin
            w_win_next[3*i]     = r_win[3*i+1];
            w_win_next[3*i + 1] = r_win[3*i+2];
        end
        w_win_next[2] = w_lb1_rd;
        w_win_next[5] = w_lb0_rd;
        w_win_next[8] = pix_in;
    end

    // The window register doubles as the output stage: a pixel is only
    // accepted when the current window is absent or being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else if (clear) begin
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            if (w_fire) begin
                r_win_valid <= 1'b0;
                r_win_last  <= 1'b0;
            end
            if (w_accept) begin
                r_win <= w_win_next;
                if (w_col_end) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= w_row_end ? '0 : r_row_cnt + R_CNT_W'(1);
                end else begin
                    r_col_cnt <= r_col_cnt + C_CNT_W'(1);
                end
                if (w_emit) begin
                    r_win_valid <= 1'b1;
                    r_win_last  <= w_row_end && w_col_end;
                    r_win_row   <= ROW_W'(r_row_cnt - R_CNT_W'(2));
                    r_win_col   <= COL_W'(r_col_cnt - C_CNT_W'(2));
                end
            end
        end
    end

    assign win_data  = r_win;
    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;

`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_stall_cnt <= '0;
        end else if (r_win_valid && !win_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_gen
// Brief    : Scoreboard bench for conv_window_gen (28x28 and 3x3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;
    import cnn_pkg::*;

    localparam int H = 28;
    localparam int W = 28;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, pix_valid, pix_ready, win_valid, win_ready, win_last;
    logic [7:0]  pix_in;
    logic [71:0] win_data;
    logic [4:0]  win_row, win_col;

    logic        clear3, p3_valid, p3_ready, w3_valid, w3_ready, w3_last;
    logic [7:0]  p3_in;
    logic [71:0] w3_data;
    logic [0:0]  w3_row, w3_col;
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
    logic [31:0] stall_cnt, stall_cnt3;
`endif

    conv_window_gen #(.IMG_HEIGHT(H), .IMG_WIDTH(W), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .win_data(win_data),
        .win_row(win_row), .win_col(win_col), .win_valid(win_valid),
        .win_ready(win_ready), .win_last(win_last)
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    conv_window_gen #(.IMG_HEIGHT(3), .IMG_WIDTH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clear3), .pix_in(p3_in),
        .pix_valid(p3_valid), .pix_ready(p3_ready), .win_data(w3_data),
        .win_row(w3_row), .win_col(w3_col), .win_valid(w3_valid),
        .win_ready(w3_ready), .win_last(w3_last)
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
        , .stall_cnt(stall_cnt3)
`endif
    );

    typedef struct packed {
        logic [4:0]  row;
        logic [4:0]  col;
        logic        last;
        logic [71:0] data;
    } exp_t;

    typedef struct {
        int frames;
        int pv_pct;
        int wr_pct;
        bit ramp;
        int stall_at;
        int exp_win;
    } vec_t;

    exp_t        sb[$];
    vec_t        tab[3];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  img [H][W];
    int          mr, mc, nacc, nwin, nlast, first_acc, acc_since_rst;
    logic [71:0] first_data;
    logic [7:0]  last_k8;
    logic [9:0]  last_pos;
    logic [7:0]  cur_rand;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ramp(input int r, input int c);
        return 8'((r * W + c) % 256);
    endfunction

    task automatic model_reset();
        mr = 0;
        mc = 0;
        sb.delete();
        first_acc = -1;
        acc_since_rst = 0;
    endtask

    // One clock: score outputs at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst_n && win_valid && first_acc < 0) begin
            first_acc  = acc_since_rst;
            first_data = win_data;
        end
        if (rst_n && win_valid && win_ready) begin
            nwin++;
            if (win_last) begin
                nlast++;
                last_k8  = win_data[71:64];
                last_pos = {win_row, win_col};
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: got row %0d col %0d, required no window", win_row, win_col);
            end else begin
                e = sb.pop_front();
                chk("window", 128'({win_row, win_col, win_last, win_data}), 128'(e));
            end
        end
        if (!rst_n || clear) begin
            model_reset();
        end else if (pix_valid && pix_ready) begin
            img[mr][mc] = pix_in;
            acc_since_rst++;
            nacc++;
            cur_rand = 8'($urandom);
            if (mr >= 2 && mc >= 2) begin
                e.row  = 5'(mr - 2);
                e.col  = 5'(mc - 2);
                e.last = (mr == H - 1) && (mc == W - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.data[(3*i+j)*8 +: 8] = img[mr-2+i][mc-2+j];
                sb.push_back(e);
            end
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input int pv_pct, input int wr_pct, input bit use_ramp);
        pix_valid = (int'($urandom_range(99)) < pv_pct);
        win_ready = (int'($urandom_range(99)) < wr_pct);
        pix_in    = use_ramp ? ramp(mr, mc) : cur_rand;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clear     = 1'b0;
        pix_valid = 1'b0;
        win_ready = 1'b1;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic run_frames(input vec_t v);
        int          target;
        int          budget;
        int          n_start;
        bit          stalled;
        logic [71:0] sd;
        logic [4:0]  sr, sc;
        target  = nacc + v.frames * H * W;
        budget  = 0;
        n_start = nwin;
        stalled = 1'b0;
        while (nacc < target && budget < 40 * H * W * v.frames) begin
            if (v.stall_at >= 0 && !stalled && (nwin - n_start) >= v.stall_at && win_valid) begin
                stalled = 1'b1;
                sd = win_data;
                sr = win_row;
                sc = win_col;
                for (int k = 0; k < 5; k++) begin
                    pix_valid = 1'b1;
                    win_ready = 1'b0;
                    pix_in    = v.ramp ? ramp(mr, mc) : cur_rand;
                    cycle();
                    budget++;
                    chk("stall_pix_ready", 128'(pix_ready), 128'(0));
                    chk("stall_data", 128'(win_data), 128'(sd));
                    chk("stall_rowcol", 128'({win_row, win_col}), 128'({sr, sc}));
                end
            end
            set_inputs(v.pv_pct, v.wr_pct, v.ramp);
            cycle();
            budget++;
        end
        if (nacc < target) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: got %0d accepts, required %0d", nacc, target);
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        for (int k = 0; k < 200 && sb.size() > 0; k++) cycle();
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [71:0] exp_first;
        logic [71:0] snap;
        logic [7:0]  px [18];
        logic [71:0] e3;
        int          n0, b, k3, n3;

        exp_first = {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0};
        tab[0] = '{1, 100, 100, 1, -1, 676};
        tab[1] = '{1, 100, 100, 1, 100, 676};
        tab[2] = '{3, 60, 50, 0, -1, 2028};

        rst_n = 1'b0; clear = 1'b0; pix_valid = 1'b0; win_ready = 1'b1; pix_in = '0;
        clear3 = 1'b0; p3_valid = 1'b0; p3_in = '0; w3_ready = 1'b1;
        cur_rand = '0; nacc = 0; nwin = 0; nlast = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_valid", 128'(win_valid), 128'(0));
        chk("rst_last", 128'(win_last), 128'(0));
        chk("rst_rowcol", 128'({win_row, win_col}), 128'(0));
        chk("rst_data", 128'(win_data), 128'(0));
        chk("rst_pix_ready", 128'(pix_ready), 128'(1));

        for (int i = 0; i < 3; i++) begin
            do_reset();
            n0 = nwin;
            nlast = 0;
            run_frames(tab[i]);
            chk("win_count", 128'(nwin - n0), 128'(tab[i].exp_win));
            if (tab[i].ramp) begin
                chk("first_latency", 128'(first_acc), 128'(59));
                chk("first_data", 128'(first_data), 128'(exp_first));
                chk("last_count", 128'(nlast), 128'(1));
                chk("last_k8", 128'(last_k8), 128'(15));
                chk("last_pos", 128'(last_pos), 128'({5'd25, 5'd25}));
            end
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
            if (tab[i].stall_at >= 0) chk("stall_cnt", 128'(stall_cnt), 128'(5));
`endif
        end

        // clear with a window pending at input pixel (10,5)
        do_reset();
        b = 0;
        while (!(mr == 10 && mc == 5) && b < 2000) begin
            set_inputs(100, 100, 1'b1);
            cycle();
            b++;
        end
        chk("clear_pre_valid", 128'(win_valid), 128'(1));
        snap = win_data;
        clear = 1'b1; pix_valid = 1'b1; win_ready = 1'b1; pix_in = ramp(mr, mc);
        cycle();
        clear = 1'b0;
        chk("clear_valid", 128'(win_valid), 128'(0));
        chk("clear_rowcol_last", 128'({win_row, win_col, win_last}), 128'(0));
        chk("clear_data_hold", 128'(win_data), 128'(snap));
        n0 = nwin;
        run_frames('{1, 100, 100, 1, -1, 676});
        chk("clear_refeed_count", 128'(nwin - n0), 128'(676));

        // one-cycle reset mid-frame with a window held
        do_reset();
        n0 = nwin;
        b = 0;
        while (!((nwin - n0) >= 50 && win_valid) && b < 2000) begin
            set_inputs(100, 100, 1'b1);
            cycle();
            b++;
        end
        rst_n = 1'b0; pix_valid = 1'b1; win_ready = 1'b0;
        cycle();
        chk("midrst_valid", 128'(win_valid), 128'(0));
        chk("midrst_rowcol_last", 128'({win_row, win_col, win_last}), 128'(0));
        chk("midrst_data", 128'(win_data), 128'(0));
        chk("midrst_pix_ready", 128'(pix_ready), 128'(1));
        rst_n = 1'b1;
        n0 = nwin;
        run_frames('{1, 100, 100, 1, -1, 676});
        chk("midrst_refeed_count", 128'(nwin - n0), 128'(676));

        // 3x3 minimum frame, two frames back to back
        do_reset();
        chk("min_rst_valid", 128'(w3_valid), 128'(0));
        chk("min_rst_data", 128'(w3_data), 128'(0));
        for (int i = 0; i < 18; i++) px[i] = 8'($urandom);
        k3 = 0;
        n3 = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            p3_valid = (k3 < 18);
            p3_in    = px[(k3 < 18) ? k3 : 0];
            w3_ready = 1'b1;
            @(negedge clk);
            if (w3_valid && w3_ready) begin
                if (n3 < 2) begin
                    for (int m = 0; m < 9; m++) e3[m*8 +: 8] = px[9*n3 + m];
                    chk("min_data", 128'(w3_data), 128'(e3));
                    chk("min_last_pos", 128'({w3_last, w3_row, w3_col}), 128'(3'b100));
                end
                n3++;
            end
            if (p3_valid && p3_ready) k3++;
            @(posedge clk);
            #1;
        end
        p3_valid = 1'b0;
        chk("min_count", 128'(n3), 128'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 sliding-window generator that sits directly upstream of the convolution datapath and its output address sequencing.
- Accepts one raster-order pixel per cycle and keeps two row line buffers plus a 3x3 register window.
- Emits every valid (unpadded, stride-1) 3x3 window with output coordinates.
- Downstream uses win_valid && win_ready as its per-window advance event; each frame yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows.

Parameters:
- IMG_HEIGHT, 28, input frame rows (min 3)
- IMG_WIDTH, 28, input frame columns (min 3)
- DATA_W, 8, pixel width in bits

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous frame restart, same effect as reset on counters and valid
- pix_in  in  DATA_W  input pixel
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block can accept pix_in this cycle
- win_data  out  9*DATA_W  window; slice k=3*i+j holds pixel (row+i, col+j), k=0 top-left, k=8 bottom-right
- win_row  out  $clog2(IMG_HEIGHT-2)  output row of window
- win_col  out  $clog2(IMG_WIDTH-2)  output column of window
- win_valid  out  1  window valid
- win_ready  in  1  downstream accepts window
- win_last  out  1  qualifies final window of frame

Behaviour:
- Reset (rst_n=0 at clk edge): win_valid=0, win_last=0, win_row=0, win_col=0, win_data=0, input row/col counters=0; pix_ready=1 from the following cycle. Line-buffer contents are not reset.
- clear: same as reset except win_data holds. rst_n has priority over clear. clear has priority over any accept in the same cycle (that pixel is dropped).
- Accept: pixel accepted when pix_valid && pix_ready. pix_ready = !win_valid || win_ready (single output stage, combinational back-pressure).
- Per accepted pixel at input (r,c):
  - Shift the 3x3 window left, loading the new right column {lb1[c], lb0[c], pix_in}, top to bottom.
  - lb1[c] <= lb0[c]; lb0[c] <= pix_in.
  - Advance c; at IMG_WIDTH-1 wrap c to 0 and advance r; at (IMG_HEIGHT-1, IMG_WIDTH-1) wrap both to 0.
- Window emit: if the accepted pixel has r>=2 && c>=2, then the next cycle win_valid=1, win_row=r-2, win_col=c-2, win_data=updated window. Latency from accept to window is 1 cycle.
- Window hold: win_valid, win_data, win_row, win_col and win_last hold stable until win_valid && win_ready.
- Window drop: win_valid drops after the handshake unless a new window is loaded in the same cycle. Back-to-back windows at one per cycle are possible when win_ready=1.
- Row-start pixels (c<2) and first-two-row pixels only fill buffers; win_valid is not set for them.
- win_last=1 exactly with the window at (IMG_HEIGHT-3, IMG_WIDTH-3). The next frame may start streaming the following cycle with no bubble.
- No FSM states beyond fill/run, which are implied by the counters. No internal overflow: stalls propagate via pix_ready.
- Widths: counters sized $clog2 of their range. All comparisons against localparams OUT_H=IMG_HEIGHT-2 and OUT_W=IMG_WIDTH-2.

Optional Feature:
- Macro: CONV_WINDOW_GEN_STALL_CNT_EN
- Defined: adds output port stall_cnt[31:0], counting cycles with win_valid && !win_ready. It saturates at all-ones, is zeroed by reset and clear, and does not wrap.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W default, IMG_HEIGHT, IMG_WIDTH
  - localparams OUT_H, OUT_W, WIN_SIZE=9
  - typedef pixel_t
  - typedef window_t (packed array of 9 pixel_t)
- One sub-module, cnn_line_buffer: a single-row IMG_WIDTH-deep read-then-write buffer (one read and one write per accept at the same column index). Instantiated twice, for lb0 and lb1. Inferable as distributed RAM.

Test Plan:
- Ramp frame: pix=(r*28+c)%256, pix_valid and win_ready always 1.
  - First win_valid appears one cycle after pixel index 58 is accepted.
  - First window: row=0, col=0, data {0,1,2,28,29,30,56,57,58}.
  - Exactly 676 windows, win_last only on (25,25) with k=8 data 15 (783%256).
- Back-pressure: drop win_ready for 5 cycles while win_valid=1.
  - win_data, win_row and win_col stay constant, pix_ready=0, no pixel lost.
  - Window count still 676.
- Random pix_valid gaps plus random win_ready (50%) over 3 back-to-back frames: the scoreboard matches the golden 3x3 model for all 2028 windows, in order.
- clear asserted at input pixel (10,5) with win_valid=1:
  - Next cycle win_valid=0 and counters are 0.
  - The refed full frame produces 676 correct windows.
- rst_n low for 1 cycle mid-frame: all outputs take reset values at the next edge, and pix_ready=1 the cycle after.
- Minimum size IMG_HEIGHT=IMG_WIDTH=3: exactly 1 window, win_last=1, data equals the 9 input pixels in order.
- With CONV_WINDOW_GEN_STALL_CNT_EN: the 5-cycle stall scenario yields stall_cnt=5.
